// File: rtl/sfm_fp_minmax_upd_queue.sv
// Queue of (old, new) running-extreme pairs feeding the softmax denominator-rescaling datapath.
// Optional tail-merge when full: define SFM_UPD_COALESCE_EN.

package fpnew_pkg;
  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4,
    FP8ALT  = 3'd5
  } fp_format_e;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP16:    return 16;
      FP16ALT: return 16;
      default: return 8;
    endcase
  endfunction
endpackage

module sfm_fp_minmax_upd_queue #(
  parameter fpnew_pkg::fp_format_e FPFORMAT  = fpnew_pkg::FP16ALT,
  parameter int unsigned           DEPTH     = 2,
  parameter int unsigned           CNT_WIDTH = 16,
  localparam int unsigned          WIDTH     = fpnew_pkg::fp_width(FPFORMAT)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 new_flg_i,
  input  logic [WIDTH-1:0]     old_i,
  input  logic [WIDTH-1:0]     new_i,
  output logic                 upd_valid_o,
  input  logic                 upd_ready_i,
  output logic [WIDTH-1:0]     upd_old_o,
  output logic [WIDTH-1:0]     upd_new_o,
  output logic                 empty_o,
  output logic [CNT_WIDTH-1:0] upd_cnt_o
);

  localparam int unsigned      OCC_W    = $clog2(DEPTH + 1);
  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0]     old_q [DEPTH];
  logic [WIDTH-1:0]     old_d [DEPTH];
  logic [WIDTH-1:0]     new_q [DEPTH];
  logic [WIDTH-1:0]     new_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     tail_ptr;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic full, empty, push, pop, merge, append;

  always_comb begin
    full     = (occ_q == OCC_FULL);
    empty    = (occ_q == '0);
    pop      = ~empty & upd_ready_i;
    tail_ptr = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - PTR_W'(1);

`ifdef SFM_UPD_COALESCE_EN
    // Only a lone, presented-but-unaccepted head (DEPTH=1) can block a merge.
    ready_o = ~new_flg_i | ~full | pop | (DEPTH > 1);
    push    = valid_i & ready_o & new_flg_i;
    // A full queue that pops this cycle takes the beat as an ordinary append.
    merge   = push & full & ~pop;
`else
    ready_o = ~new_flg_i | ~full;
    push    = valid_i & ready_o & new_flg_i;
    merge   = 1'b0;
`endif
    append = push & ~merge;

    old_d    = old_q;
    new_d    = new_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;

    if (append) begin
      old_d[wr_ptr_q] = old_i;
      new_d[wr_ptr_q] = new_i;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (merge) begin
      new_d[tail_ptr] = new_i;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({append, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (push && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    // Clear mirrors reset exactly, overriding any push/pop this cycle.
    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        old_d[i] = '0;
        new_d[i] = '0;
      end
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        old_q[i] <= '0;
        new_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        old_q[i] <= old_d[i];
        new_q[i] <= new_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

  assign upd_valid_o = ~empty;
  assign empty_o     = empty;
  assign upd_old_o   = old_q[rd_ptr_q];
  assign upd_new_o   = new_q[rd_ptr_q];
  assign upd_cnt_o   = cnt_q;

endmodule
